// File: rtl/flot_mul_issue_pkg.sv
// Shared float-format defaults, multiplier latency and small helpers for
// the flot_mul operand path.
package flot_mul_issue_pkg;

    localparam int FLOT_WIDTH       = 64;
    localparam int FLOT_WIDTH_EXP   = 11;
    localparam int FLOT_WIDTH_MAT   = 52;
    localparam int MUL_LAT_FLOT_MUL = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Smallest r with 2**r >= n.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Exponent field position inside {exp, mantissa}.
    function automatic int exp_field_lsb(input int w_mat);
        return w_mat;
    endfunction

    function automatic int exp_field_msb(input int w_exp, input int w_mat);
        return w_mat + w_exp - 1;
    endfunction

endpackage

// File: rtl/flot_mul_issue_if.sv
// Coefficient-write, sample handshake, operand and result-tracking bundle
// of the flot_mul operand sequencer.
interface flot_mul_issue_if
    import flot_mul_issue_pkg::*;
#(
    parameter int WIDTH = FLOT_WIDTH,
    parameter int TW    = 3
);
    logic             coef_we;
    logic [TW-1:0]    coef_addr;
    logic [WIDTH-1:0] coef_wdata;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             busy;
    logic [WIDTH-1:0] mul_op1;
    logic [WIDTH-1:0] mul_op2;
    logic             mul_exce;
    logic             r_valid;
    logic [TW-1:0]    r_tap;
    logic             r_zero;
    logic             r_last;

    modport master (
        output coef_we, coef_addr, coef_wdata, s_valid, s_data,
        input  s_ready, busy, mul_op1, mul_op2, mul_exce,
               r_valid, r_tap, r_zero, r_last
    );

    modport slave (
        input  coef_we, coef_addr, coef_wdata, s_valid, s_data,
        output s_ready, busy, mul_op1, mul_op2, mul_exce,
               r_valid, r_tap, r_zero, r_last
    );
endinterface

// File: rtl/flot_mul_issue_classify.sv
// Combinational operand classifier: flags inf/NaN/denormal as special and
// +/-0 as zero. Takes exponent+mantissa only; the sign never matters here.
module flot_classify
    import flot_mul_issue_pkg::*;
#(
    parameter int WIDTH_exp = FLOT_WIDTH_EXP,
    parameter int WIDTH_mat = FLOT_WIDTH_MAT
) (
    input  logic [WIDTH_exp+WIDTH_mat-1:0] x_mag,
    output logic                           special,
    output logic                           zero
);
    localparam int EXP_MSB = exp_field_msb(WIDTH_exp, WIDTH_mat);
    localparam int EXP_LSB = exp_field_lsb(WIDTH_mat);

    logic [WIDTH_exp-1:0] e;
    logic [WIDTH_mat-1:0] m;

    assign e = x_mag[EXP_MSB:EXP_LSB];
    assign m = x_mag[WIDTH_mat-1:0];

    // special = exponent all ones, or denormal; zero = all bits clear
    always_comb begin
        special = (&e) | ((~|e) & (|m));
        zero    = (~|e) & (~|m);
    end
endmodule

// File: rtl/flot_mul_issue.sv
// Operand sequencer for one IIR tap bank feeding flot_mul_pipe. Each
// accepted sample shifts the delay line and issues TAPS coef x sample pairs
// back to back; a MUL_LAT-deep tag pipe lines up tap/zero/last with the
// multiplier result.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | ready for a sample, coefficient writes accepted
//   ST_ISSUE | presenting pair k_q this cycle, k_q = 0..TAPS-1
//   ST_DRAIN | operands zero, waiting for the last-tap result to emerge
module flot_mul_issue
    import flot_mul_issue_pkg::*;
#(
    parameter int WIDTH     = FLOT_WIDTH,
    parameter int WIDTH_exp = FLOT_WIDTH_EXP,
    parameter int WIDTH_mat = FLOT_WIDTH_MAT,
    parameter int TAPS      = 5,
    parameter int MUL_LAT   = MUL_LAT_FLOT_MUL
) (
    input  logic CLK,
    input  logic nRST,
    flot_mul_issue_if.slave bus
);
    localparam int            TW       = log2_ceil(TAPS);
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

    seq_state_e       state, state_nxt;
    logic [WIDTH-1:0] coef     [TAPS];
    logic [WIDTH-1:0] coef_eff [TAPS];
    logic [WIDTH-1:0] x_dl     [TAPS];
    logic [WIDTH-1:0] x_eff    [TAPS];
    logic             accept, issue_nxt;
    logic [TW-1:0]    idx_nxt, k_q;
    logic [WIDTH-1:0] op1_d, op2_d, op1_q, op2_q;
    logic             sp1, sp2, z1, z2, exce_d, zero_d;
    logic             exce_q, zero_q, issue_q, last_q;
    logic [MUL_LAT-1:0] pv, pz, pl;
    logic [TW-1:0]      pt [MUL_LAT];

    assign accept = bus.s_valid & bus.s_ready;

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // next-state: ISSUE ends after the last tap, DRAIN ends on the last result
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)          state_nxt = ST_ISSUE;
            ST_ISSUE: if (k_q == LAST_TAP) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pl[MUL_LAT-1])   state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and which pair gets registered at the next edge
    always_comb begin
        bus.s_ready = 1'b0;
        bus.busy    = 1'b1;
        issue_nxt   = 1'b0;
        idx_nxt     = '0;
        case (state)
            ST_IDLE: begin
                bus.s_ready = nRST;
                bus.busy    = 1'b0;
                issue_nxt   = bus.s_valid & nRST;
            end
            ST_ISSUE: begin
                issue_nxt = (k_q != LAST_TAP);
                idx_nxt   = (k_q != LAST_TAP) ? k_q + TW'(1) : '0;
            end
            default: ;
        endcase
    end

    // coefficient view with an IDLE write already applied, so a sample taken
    // in the same cycle sees the new value; out-of-range addresses match nothing
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef_eff[i] = coef[i];
            if (state == ST_IDLE && bus.coef_we && bus.coef_addr == TW'(i))
                coef_eff[i] = bus.coef_wdata;
        end
    end

    // delay line view after the shift caused by an accept
    always_comb begin
        x_eff[0] = accept ? bus.s_data : x_dl[0];
        for (int i = 1; i < TAPS; i++)
            x_eff[i] = accept ? x_dl[i-1] : x_dl[i];
    end

    assign op1_d = issue_nxt ? coef_eff[idx_nxt] : '0;
    assign op2_d = issue_nxt ? x_eff[idx_nxt]    : '0;

    flot_classify #(.WIDTH_exp(WIDTH_exp), .WIDTH_mat(WIDTH_mat)) u_cls_op1 (
        .x_mag(op1_d[WIDTH-2:0]), .special(sp1), .zero(z1)
    );
    flot_classify #(.WIDTH_exp(WIDTH_exp), .WIDTH_mat(WIDTH_mat)) u_cls_op2 (
        .x_mag(op2_d[WIDTH-2:0]), .special(sp2), .zero(z2)
    );

    assign exce_d = sp1 | sp2;
    assign zero_d = (z1 | z2) & ~exce_d & issue_nxt;

    // coefficient bank and sample delay line
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
                x_dl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= coef_eff[i];
                x_dl[i] <= x_eff[i];
            end
        end
    end

    // operand register presented to the multiplier, with its classification
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op1_q   <= '0;
            op2_q   <= '0;
            exce_q  <= 1'b0;
            zero_q  <= 1'b0;
            issue_q <= 1'b0;
            k_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            exce_q  <= exce_d;
            zero_q  <= zero_d;
            issue_q <= issue_nxt;
            k_q     <= idx_nxt;
            last_q  <= issue_nxt && (idx_nxt == LAST_TAP);
        end
    end

    // tag pipe matching the multiplier latency; cleared by reset so pairs
    // still in flight never report a result
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pv <= '0;
            pz <= '0;
            pl <= '0;
            for (int i = 0; i < MUL_LAT; i++) pt[i] <= '0;
        end else begin
            pv    <= {pv[MUL_LAT-2:0], issue_q};
            pz    <= {pz[MUL_LAT-2:0], zero_q};
            pl    <= {pl[MUL_LAT-2:0], last_q};
            pt[0] <= k_q;
            for (int i = 1; i < MUL_LAT; i++) pt[i] <= pt[i-1];
        end
    end

    assign bus.mul_op1  = op1_q;
    assign bus.mul_op2  = op2_q;
    assign bus.mul_exce = exce_q;
    assign bus.r_valid  = pv[MUL_LAT-1];
    assign bus.r_tap    = pt[MUL_LAT-1];
    assign bus.r_zero   = pz[MUL_LAT-1];
    assign bus.r_last   = pl[MUL_LAT-1];
endmodule

// File: tb/tb_flot_mul_issue.sv
// Bench for flot_mul_issue: scoreboard of expected operand pairs and tagged
// results, filled from a reference model of coefficients and delay line.
module tb_flot_mul_issue;
    localparam int TAPS    = 5;
    localparam int MUL_LAT = 6;
    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] HALF = 64'h3FE0000000000000;
    localparam logic [63:0] FIVE = 64'h4014000000000000;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] DEN  = 64'h0000000000000001;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic        exce;
    } op_exp_t;

    typedef struct packed {
        logic [2:0] tap;
        logic       zero;
        logic       last;
    } res_exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] m_coef [TAPS];
    logic [63:0] m_x    [TAPS];
    op_exp_t     op_q[$];
    res_exp_t    res_q[$];

    always #5 CLK = ~CLK;

    flot_mul_issue_if bus_if ();

    flot_mul_issue dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus_if)
    );

    function automatic logic f_special(input logic [63:0] v);
        logic [10:0] e;
        logic [51:0] m;
        e = v[62:52];
        m = v[51:0];
        return (e == 11'h7FF) || (e == 11'h000 && m != 52'h0);
    endfunction

    function automatic logic f_zero(input logic [63:0] v);
        return v[62:0] == 63'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = '0;
            m_x[i]    = '0;
        end
        op_q.delete();
        res_q.delete();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus_if.coef_we = 1'b0;
        bus_if.s_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [63:0] d);
        bus_if.coef_we    = 1'b1;
        bus_if.coef_addr  = a;
        bus_if.coef_wdata = d;
        if (int'(a) < TAPS) m_coef[a] = d;
        @(negedge CLK);
        bus_if.coef_we = 1'b0;
    endtask

    task automatic push_expect(input logic [63:0] s);
        logic [63:0] e1, e2;
        logic        ex;
        for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
        for (int k = 0; k < TAPS; k++) begin
            e1 = m_coef[k];
            e2 = m_x[k];
            ex = f_special(e1) | f_special(e2);
            op_q.push_back('{op1: e1, op2: e2, exce: ex});
            res_q.push_back('{tap: 3'(k), zero: (f_zero(e1) | f_zero(e2)) & ~ex,
                              last: (k == TAPS - 1)});
        end
    endtask

    // Offers one sample at a negedge and follows it through TAPS+MUL_LAT+1
    // negedges; returns on the first IDLE negedge after the drain.
    task automatic run_sample(input logic [63:0] s, input bit hold,
                              input bit busy_wr, input string name);
        int       wait_n;
        op_exp_t  oe;
        res_exp_t re;
        wait_n = 0;
        while (bus_if.s_ready !== 1'b1 && wait_n < 20) begin
            @(negedge CLK);
            wait_n++;
        end
        checks++;
        if (bus_if.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: s_ready=%b required 1", name, bus_if.s_ready);
            return;
        end
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = s;
        push_expect(s);
        for (int n = 1; n <= TAPS + MUL_LAT + 1; n++) begin
            @(negedge CLK);
            checks++;
            if (bus_if.s_ready !== (n == TAPS + MUL_LAT + 1) ||
                bus_if.busy    !== (n <= TAPS + MUL_LAT)) begin
                errors++;
                $display("FAIL %s hs n=%0d: ready/busy=%b%b required %b%b", name, n,
                         bus_if.s_ready, bus_if.busy,
                         n == TAPS + MUL_LAT + 1, n <= TAPS + MUL_LAT);
            end
            if (n <= TAPS) begin
                oe = op_q.pop_front();
                checks++;
                if ({bus_if.mul_op1, bus_if.mul_op2, bus_if.mul_exce} !== {oe.op1, oe.op2, oe.exce}) begin
                    errors++;
                    $display("FAIL %s op k=%0d: op1=%h op2=%h exce=%b required %h %h %b", name, n - 1,
                             bus_if.mul_op1, bus_if.mul_op2, bus_if.mul_exce, oe.op1, oe.op2, oe.exce);
                end
            end else begin
                checks++;
                if ({bus_if.mul_op1, bus_if.mul_op2, bus_if.mul_exce} !== 129'h0) begin
                    errors++;
                    $display("FAIL %s op_idle n=%0d: op1=%h op2=%h exce=%b required zeros", name, n,
                             bus_if.mul_op1, bus_if.mul_op2, bus_if.mul_exce);
                end
            end
            if (n >= MUL_LAT + 1 && n <= MUL_LAT + TAPS) begin
                re = res_q.pop_front();
                checks++;
                if ({bus_if.r_valid, bus_if.r_tap, bus_if.r_zero, bus_if.r_last} !==
                    {1'b1, re.tap, re.zero, re.last}) begin
                    errors++;
                    $display("FAIL %s res n=%0d: v/tap/zero/last=%b/%0d/%b/%b required 1/%0d/%b/%b",
                             name, n, bus_if.r_valid, bus_if.r_tap, bus_if.r_zero, bus_if.r_last,
                             re.tap, re.zero, re.last);
                end
            end else begin
                checks++;
                if (bus_if.r_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s res_idle n=%0d: r_valid=%b required 0", name, n, bus_if.r_valid);
                end
            end
            if (n == 1) begin
                bus_if.coef_we = 1'b0;
                if (!hold) bus_if.s_valid = 1'b0;
            end
            if (busy_wr && n == 2) begin
                bus_if.coef_we    = 1'b1;
                bus_if.coef_addr  = 3'd1;
                bus_if.coef_wdata = FIVE;
            end
            if (busy_wr && n == 3) bus_if.coef_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if ({bus_if.s_ready, bus_if.busy, bus_if.r_valid, bus_if.mul_exce} !== 4'b0000 ||
            bus_if.mul_op1 !== 64'h0 || bus_if.mul_op2 !== 64'h0) begin
            errors++;
            $display("FAIL reset_hold: ready/busy/rv/exce=%b%b%b%b op1=%h op2=%h required zeros",
                     bus_if.s_ready, bus_if.busy, bus_if.r_valid, bus_if.mul_exce,
                     bus_if.mul_op1, bus_if.mul_op2);
        end
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus_if.s_ready, bus_if.busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/busy=%b%b required 10", bus_if.s_ready, bus_if.busy);
        end
    endtask

    task automatic test_issue();
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), ONE);
        run_sample(TWO, 1'b0, 1'b0, "issue");
    endtask

    task automatic test_delay_line();
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), ONE);
        run_sample(ONE,  1'b1, 1'b0, "dl1");
        run_sample(TWO,  1'b1, 1'b0, "dl2");
        run_sample(HALF, 1'b0, 1'b0, "dl3");
    endtask

    task automatic test_specials();
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), ONE);
        write_coef(3'd2, PINF);
        write_coef(3'd3, DEN);
        run_sample(64'h0, 1'b0, 1'b0, "spec_zero");
        run_sample(TWO,   1'b0, 1'b0, "spec_two");
    endtask

    task automatic test_write_busy();
        run_sample(ONE, 1'b0, 1'b1, "wbusy");
        run_sample(TWO, 1'b0, 1'b0, "wbusy_next");
        write_coef(3'd7, FIVE);
        run_sample(HALF, 1'b0, 1'b0, "waddr7");
    endtask

    task automatic test_same_cycle();
        bus_if.coef_we    = 1'b1;
        bus_if.coef_addr  = 3'd0;
        bus_if.coef_wdata = HALF;
        m_coef[0] = HALF;
        run_sample(ONE, 1'b0, 1'b0, "same_cycle");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), ONE);
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = TWO;
        for (int n = 1; n <= 4; n++) begin
            @(negedge CLK);
            bus_if.s_valid = 1'b0;
        end
        checks++;
        if (bus_if.mul_op1 !== ONE || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_k3: op1=%h busy=%b required %h 1", bus_if.mul_op1, bus_if.busy, ONE);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if ({bus_if.s_ready, bus_if.busy, bus_if.r_valid, bus_if.mul_exce} !== 4'b0000 ||
            bus_if.mul_op1 !== 64'h0 || bus_if.mul_op2 !== 64'h0) begin
            errors++;
            $display("FAIL rmid_abort: ready/busy/rv/exce=%b%b%b%b op1=%h op2=%h required zeros",
                     bus_if.s_ready, bus_if.busy, bus_if.r_valid, bus_if.mul_exce,
                     bus_if.mul_op1, bus_if.mul_op2);
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus_if.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready: s_ready=%b required 1", bus_if.s_ready);
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            checks++;
            if (bus_if.r_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_no_result n=%0d: r_valid=%b required 0", n, bus_if.r_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.coef_we    = 1'b0;
        bus_if.coef_addr  = '0;
        bus_if.coef_wdata = '0;
        bus_if.s_valid    = 1'b0;
        bus_if.s_data     = '0;
        model_reset();
        test_reset();
        test_issue();
        test_delay_line();
        test_specials();
        test_write_busy();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flot_mul_issue.md
Name: flot_mul_issue

Overview:
- Operand sequencer for one IIR tap bank. It sits directly upstream of flot_mul_pipe.
- Holds TAPS coefficients and a TAPS-deep sample delay line.
- On each accepted sample, issues TAPS coefficient×sample operand pairs back-to-back on mul_op1/mul_op2.
- Flags operands flot_mul_pipe cannot handle via mul_exce, and tracks tap tag / zero / last flags through a shift pipe aligned to the multiplier result.

Parameters:
- WIDTH, 64, total float width.
- WIDTH_exp, 11, exponent width.
- WIDTH_mat, 52, mantissa width.
- TAPS, 5, number of taps (≥2).
- MUL_LAT, 6, cycles from operand presented to result visible in flot_mul_pipe.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index.
- coef_wdata  in  WIDTH  coefficient value.
- s_valid  in  1  input sample valid.
- s_data  in  WIDTH  input sample.
- s_ready  out  1  sample accepted when s_valid&s_ready.
- busy  out  1  sequencer not IDLE.
- mul_op1  out  WIDTH  coefficient operand, to flot_mul_pipe OP1.
- mul_op2  out  WIDTH  sample operand, to flot_mul_pipe OP2.
- mul_exce  out  1  to flot_mul_pipe exce_in.
- r_valid  out  1  flot_mul_pipe result valid this cycle.
- r_tap  out  log2(TAPS)  tap index of that result.
- r_zero  out  1  product is exact zero; downstream forces result to 0.
- r_last  out  1  result is tap TAPS-1.

Behaviour:
- Reset (async, nRST=0):
  - Coefficients and delay line cleared to 0; state IDLE.
  - mul_op1/mul_op2 = 0; all flags and pipe stages = 0.
  - s_ready=0 while nRST=0, 1 after release.
- FSM IDLE/ISSUE/DRAIN:
  - IDLE: s_ready=1, busy=0. On s_valid:
    - Delay line shifts: x[k]←x[k-1], x[0]←s_data.
    - Tap counter k←0; go ISSUE.
  - ISSUE: s_ready=0, busy=1. Registered mul_op1=coef[k], mul_op2=x[k], issue flag=1, one pair per cycle for k=0..TAPS-1. After k=TAPS-1 issued, go DRAIN.
  - DRAIN: ops held at 0, issue flag=0. Stay until the cycle r_last=1; go IDLE on the next edge.
- Issue timing:
  - Sample accepted at edge t0; pair k is presented in cycle t0+1+k.
  - Next sample is accepted no earlier than cycle t0+TAPS+MUL_LAT+1.
- Operand classification, combinational on issued operands, registered with them:
  - special(x) = exp all-ones (inf/NaN) OR (exp==0 AND mantissa≠0) (denormal).
  - mul_exce = special(op1)|special(op2).
  - zero(x) = exp==0 AND mantissa==0.
  - zero flag = (zero(op1)|zero(op2)) & ~mul_exce.
- Tracking pipe: depth MUL_LAT; shifts every cycle; carries {issue flag, k, zero flag, k==TAPS-1}. Stage MUL_LAT drives r_valid/r_tap/r_zero/r_last. r_valid for pair k is high in cycle t0+1+k+MUL_LAT, aligned with flot_mul_pipe result and exce_out.
- No backpressure: downstream must consume every r_valid cycle.
- Coefficient writes:
  - Accepted only in IDLE. coef_we while busy=1 is ignored (no side effect).
  - A write and a sample accept in the same IDLE cycle: the write lands first, so the new coefficient is used by that sample.
  - coef_addr≥TAPS is ignored.
- Reset mid-ISSUE/DRAIN: immediate abort; pipe cleared, so no r_valid after reset even for pairs already inside the multiplier.
- Width rules: coefficients and samples are stored raw, with no arithmetic on them. Counter k wraps only via state exit, never modulo.

Decomposition:
- Shared package flot_pkg: WIDTH/WIDTH_exp/WIDTH_mat defaults, MUL_LAT_FLOT_MUL=6, log2 function, exponent-field extraction constants.
- One natural sub-module: flot_classify (combinational special/zero detect, reused by the adder stage).
- Tracking pipe and FSM stay inline.

Test Plan:
- Reset/write/issue: reset, write coef[0..4]=1.0 (0x3FF0000000000000), send sample 2.0 (0x4000000000000000) -> pairs present in cycles t0+1..t0+5 with op1=1.0; op2=2.0 for k=0 and 0 for k=1..4; r_valid cycles t0+7..t0+11 with r_tap 0..4; r_zero=0,1,1,1,1; r_last only at t0+11.
- Delay line: three samples 1.0, 2.0, 0.5 (0x3FE0000000000000) with s_valid held high -> s_ready drops for 11 cycles per sample; on the third issue, op2 sequence is 0.5, 2.0, 1.0, 0, 0.
- Specials: coef[2]=+inf (0x7FF0000000000000), coef[3]=denormal 0x0000000000000001 -> mul_exce=1 on k=2 and k=3 issue cycles only; r_zero=0 for those taps even if the sample is 0.
- Write while busy: coef_we to addr 1 with 5.0 during ISSUE -> coef[1] unchanged; the next sample still uses the old value. Write to addr 7 in IDLE is ignored.
- Same-cycle write and accept: coef_we addr 0 = 0.5 with s_valid in IDLE -> k=0 op1=0.5.
- Reset mid-op: deassert nRST during k=3 of ISSUE -> outputs 0 immediately; no r_valid for 10 cycles after release; s_ready=1 after release.
